alu_wb_queue: RTL
=================

// Module: alu_wb_queue
// PURPOSE
//  Result writeback queue downstream of the integer adder.
//  Captures each registered add result and its destination register into an in-order FIFO.
//  Drains one entry per granted cycle to the register-file write port.
//  Decouples the execution stage from write-port arbitration (load unit, CSR); drops x0 and non-writing uops.
// PARAMETERS
//  DATA_WIDTH  `DATA_WIDTH (32)  result width
//  DEPTH       4                 entries; power of 2, >=2
//  RD_WIDTH    5                 architectural register index width
// PORTS
//  clk         in   1           clock
//  reset       in   1           synchronous, active-high
//  in_valid    in   1           result present; aligned with adder add_value (one cycle after uop_valid_in)
//  in_wr_en    in   1           uop writes rd
//  in_rd       in   RD_WIDTH    destination register
//  in_data     in   DATA_WIDTH  result value
//  in_ready    out  1           queue can accept; = !full
//  wb_valid    out  1           head entry valid (= !empty)
//  wb_rd       out  RD_WIDTH    head rd
//  wb_data     out  DATA_WIDTH  head data
//  wb_grant    in   1           regfile port granted; pop when wb_valid & wb_grant
//  count       out  $clog2(DEPTH)+1  occupancy
//  ovf_err     out  1           sticky: in_valid & in_wr_en & rd!=0 while !in_ready
//  fwd_rs1/2   in   RD_WIDTH    [WBQ_FWD_EN] source lookups
//  fwd_hit1/2  out  1           [WBQ_FWD_EN] pending match
//  fwd_data1/2 out  DATA_WIDTH  [WBQ_FWD_EN] youngest matching data
// BEHAVIOUR
//  - Reset: rd_ptr=wr_ptr=0, count=0, all entry valids cleared, ovf_err=0.
//    Outputs: wb_valid=0, in_ready=1, fwd_hit*=0; wb_rd/wb_data=0 while empty.
//  - Reset mid-operation flushes all pending entries; none are written back.
//  - push = in_valid & in_ready & in_wr_en & (in_rd!=0). Non-writing or x0 results are consumed, not stored.
//  - pop = wb_valid & wb_grant. wb_* driven combinationally from the head entry (first-word fall-through).
//  - Latency: a push into an empty queue appears on wb_* the cycle after the push edge. No bypass to wb_*.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - count +1 on push only, -1 on pop only, unchanged when both occur.
//  - Full: in_ready=0, including a cycle with a pop. No combinational wb_grant->in_ready path.
//    Push attempted while full: entry dropped, ovf_err set (cleared only by reset).
//  - Empty: wb_valid=0; wb_grant is ignored.
//  - Simultaneous push+pop with count==1: head pops, new entry becomes head next cycle.
//  - Drain order is strictly program (push) order.
// CONFIGURATION
//  WBQ_FWD_EN defined:
//   - fwd_hit=1 when any valid entry has rd==fwd_rs and fwd_rs!=0.
//   - fwd_data = data of the youngest (closest to wr_ptr) matching entry.
//   - An entry popping this cycle still hits.
//   - Same-cycle in_* is not forwarded; the upstream stage handles that.
//   - Search is combinational.
//  WBQ_FWD_EN undefined: fwd_* ports and match logic absent.
// STRUCTURE
//  wbq_param.vh: WBQ_DEPTH default, WBQ_PTR_W, entry field offsets {valid,rd,data}.
//  Sub-module wbq_fwd_match: age-ordered priority search over the entries.
//   - One instance per lookup port; instantiated only under WBQ_FWD_EN.
// TESTING
//  1. Reset; push rd=3 data=0x11 -> next cycle wb_valid=1 wb_rd=3 wb_data=0x11; grant -> empty, count=0.
//  2. Push rd=0 and push in_wr_en=0 -> count stays 0, wb_valid=0, ovf_err=0.
//  3. Fill 4 (rd=1..4), grant=0 -> in_ready=0; 5th push -> ovf_err=1, entry lost.
//     Then drain -> rd 1,2,3,4 in order.
//  4. count=1, push+grant same cycle -> count=1, new entry at head; 10 pushes with steady grant -> pointer wrap, order kept.
//  5. [FWD_EN] Pending rd=5:0xA then rd=5:0xB, fwd_rs1=5 -> hit1=1 data1=0xB.
//     fwd_rs2=0 -> hit2=0.
//  6. Reset asserted with 3 entries pending -> next cycle wb_valid=0, count=0; no further writebacks.

Source files
------------

// File: rtl/alu_wb_queue_pkg.sv
// Shared parameters and helpers for the ALU writeback queue.
// Entry layout is {valid, rd, data}; the offsets below describe that packing.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package alu_wb_queue_pkg;
  localparam int WBQ_DEPTH     = 4;
  localparam int WBQ_PTR_W     = $clog2(WBQ_DEPTH);
  localparam int WBQ_RD_W      = 5;
  localparam int WBQ_DATA_W    = `DATA_WIDTH;
  localparam int WBQ_DATA_LSB  = 0;
  localparam int WBQ_RD_LSB    = WBQ_DATA_LSB + WBQ_DATA_W;
  localparam int WBQ_VALID_BIT = WBQ_RD_LSB + WBQ_RD_W;

  // A result is worth storing only if the uop writes a non-x0 destination.
  function automatic logic wbq_writes(input logic wr_en, input logic rd_nonzero);
    return wr_en & rd_nonzero;
  endfunction
endpackage

// File: rtl/wbq_fwd_match.sv
// Age-ordered search of the writeback queue for a pending source register.
// Scans oldest to youngest so the youngest matching entry wins.
module wbq_fwd_match
  import alu_wb_queue_pkg::*;
#(
  parameter int DEPTH      = WBQ_DEPTH,
  parameter int RD_WIDTH   = WBQ_RD_W,
  parameter int DATA_WIDTH = WBQ_DATA_W,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                 ent_valid,
  input  logic [DEPTH-1:0][RD_WIDTH-1:0]   ent_rd,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
  input  logic [PTR_W-1:0]                 rd_ptr,
  input  logic [RD_WIDTH-1:0]              rs,
  output logic                             hit,
  output logic [DATA_WIDTH-1:0]            data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (ent_valid[idx] && (ent_rd[idx] == rs) && (rs != '0)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/alu_wb_queue.sv
// In-order writeback queue between the adder and the register-file write port.
// Optional source forwarding search is enabled by defining WBQ_FWD_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module alu_wb_queue
  import alu_wb_queue_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = WBQ_DEPTH,
  parameter int RD_WIDTH   = WBQ_RD_W,
  parameter int PTR_W      = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_wr_en,
  input  logic [RD_WIDTH-1:0]   in_rd,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wb_valid,
  output logic [RD_WIDTH-1:0]   wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_grant,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf_err
`ifdef WBQ_FWD_EN
  ,
  input  logic [RD_WIDTH-1:0]   fwd_rs1,
  input  logic [RD_WIDTH-1:0]   fwd_rs2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2
`endif
);

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0][RD_WIDTH-1:0]   rd_q, rd_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             ovf_q, ovf_d;

  logic full;
  logic writes;
  logic push;
  logic pop;

  // Full depends only on registered count, so grant never reaches in_ready.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign in_ready = ~full;
  assign writes   = in_valid & wbq_writes(in_wr_en, in_rd != '0);
  assign push     = writes & ~full;
  assign wb_valid = valid_q[rd_ptr_q];
  assign pop      = wb_valid & wb_grant;
  assign wb_rd    = wb_valid ? rd_q[rd_ptr_q] : '0;
  assign wb_data  = wb_valid ? data_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign ovf_err  = ovf_q;

  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (writes & full);
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]    = in_rd;
      data_d[wr_ptr_q]  = in_data;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef WBQ_FWD_EN
  wbq_fwd_match #(
    .DEPTH(DEPTH), .RD_WIDTH(RD_WIDTH), .DATA_WIDTH(DATA_WIDTH), .PTR_W(PTR_W)
  ) u_fwd1 (
    .ent_valid(valid_q), .ent_rd(rd_q), .ent_data(data_q), .rd_ptr(rd_ptr_q),
    .rs(fwd_rs1), .hit(fwd_hit1), .data(fwd_data1)
  );

  wbq_fwd_match #(
    .DEPTH(DEPTH), .RD_WIDTH(RD_WIDTH), .DATA_WIDTH(DATA_WIDTH), .PTR_W(PTR_W)
  ) u_fwd2 (
    .ent_valid(valid_q), .ent_rd(rd_q), .ent_data(data_q), .rd_ptr(rd_ptr_q),
    .rs(fwd_rs2), .hit(fwd_hit2), .data(fwd_data2)
  );
`endif

endmodule
